// File: rtl/frame_sync_controller_if.sv
// ============================================================================
// frame_sync_controller_if : header/lock bus between the frame aligner and its users
// Rev 1.0
// ============================================================================
`default_nettype none

interface frame_sync_controller_if;
  logic       enable;
  logic       resync;
  logic [1:0] PATTERN;
  logic       shift_fr_later;
  logic       locked;
  logic       d_enb;
  logic [4:0] shift_pos;
  logic [7:0] resync_count;
  logic       search_fail;

  modport master (
    output enable, resync, PATTERN,
    input  shift_fr_later, locked, d_enb, shift_pos, resync_count, search_fail
  );

  modport slave (
    input  enable, resync, PATTERN,
    output shift_fr_later, locked, d_enb, shift_pos, resync_count, search_fail
  );
endinterface

`default_nettype wire

// File: rtl/frame_sync_controller.sv
// ============================================================================
// frame_sync_controller : header-based frame aligner driving bit-slip pulses
// Rev 1.0
// ============================================================================
`default_nettype none

module frame_sync_controller #(
  parameter logic [1:0] HEADER     = 2'b10,
  parameter int         LOCK_THR   = 16,
  parameter int         UNLOCK_THR = 4,
  parameter int         SETTLE     = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  frame_sync_controller_if.slave  fsc
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    SLIP   = 3'd2,
    WAIT   = 3'd3,
    LOCKED = 3'd4
  } state_t;

  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_THR - 1);
  localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_THR - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state, state_nx;
  logic [7:0] good_cnt, good_nx;
  logic [7:0] bad_cnt, bad_nx;
  logic [7:0] resync_cnt, resync_nx;
  logic [3:0] settle_cnt, settle_nx;
  logic [4:0] slip_cnt, slip_nx;
  logic [4:0] pos, pos_nx;
  logic       pulse, pulse_nx;
  logic       lock, lock_nx;
  logic       fail, fail_nx;
  logic       match;

  assign match = (fsc.PATTERN == HEADER);

  always_comb begin
    state_nx  = state;
    good_nx   = good_cnt;
    bad_nx    = bad_cnt;
    resync_nx = resync_cnt;
    settle_nx = settle_cnt;
    slip_nx   = slip_cnt;
    pos_nx    = pos;
    pulse_nx  = 1'b0;
    lock_nx   = lock;
    fail_nx   = fail;

    if (!fsc.enable) begin
      state_nx  = IDLE;
      good_nx   = '0;
      bad_nx    = '0;
      settle_nx = '0;
      slip_nx   = '0;
      lock_nx   = 1'b0;
    end else if (fsc.resync && state != IDLE) begin
      state_nx  = SEARCH;
      good_nx   = '0;
      bad_nx    = '0;
      settle_nx = '0;
      slip_nx   = '0;
      lock_nx   = 1'b0;
      fail_nx   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = SEARCH;
          good_nx  = '0;
        end
        SEARCH: begin
          if (match) begin
            if (good_cnt == LOCK_LAST) begin
              state_nx = LOCKED;
              lock_nx  = 1'b1;
              good_nx  = '0;
              bad_nx   = '0;
            end else begin
              good_nx = good_cnt + 8'd1;
            end
          end else begin
            // The pulse and both position counters move together at slip entry
            state_nx = SLIP;
            good_nx  = '0;
            pulse_nx = 1'b1;
            pos_nx   = pos + 5'd1;
            slip_nx  = slip_cnt + 5'd1;
            if (slip_cnt == 5'd31) fail_nx = 1'b1;
          end
        end
        SLIP: begin
          state_nx  = WAIT;
          settle_nx = '0;
        end
        WAIT: begin
          if (settle_cnt == SETTLE_LAST) begin
            state_nx  = SEARCH;
            settle_nx = '0;
            good_nx   = '0;
          end else begin
            settle_nx = settle_cnt + 4'd1;
          end
        end
        LOCKED: begin
          if (match) begin
            bad_nx = '0;
          end else if (bad_cnt == UNLOCK_LAST) begin
            state_nx = SEARCH;
            lock_nx  = 1'b0;
            bad_nx   = '0;
            good_nx  = '0;
            slip_nx  = '0;
            if (resync_cnt != 8'hFF) resync_nx = resync_cnt + 8'd1;
          end else begin
            bad_nx = bad_cnt + 8'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      resync_cnt <= '0;
      settle_cnt <= '0;
      slip_cnt   <= '0;
      pos        <= '0;
      pulse      <= 1'b0;
      lock       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_nx;
      good_cnt   <= good_nx;
      bad_cnt    <= bad_nx;
      resync_cnt <= resync_nx;
      settle_cnt <= settle_nx;
      slip_cnt   <= slip_nx;
      pos        <= pos_nx;
      pulse      <= pulse_nx;
      lock       <= lock_nx;
      fail       <= fail_nx;
    end
  end

  assign fsc.shift_fr_later = pulse;
  assign fsc.locked         = lock;
  assign fsc.d_enb          = lock;
  assign fsc.shift_pos      = pos;
  assign fsc.resync_count   = resync_cnt;
  assign fsc.search_fail    = fail;

endmodule

`default_nettype wire

// File: tb/tb_frame_sync_controller.sv
// ============================================================================
// tb_frame_sync_controller : directed self-checking bench for the frame aligner
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_frame_sync_controller;

  localparam logic [1:0] HDR = 2'b10;
  localparam logic [1:0] BAD = 2'b01;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_bad;

  frame_sync_controller_if bus ();

  frame_sync_controller #(
    .HEADER     (HDR),
    .LOCK_THR   (16),
    .UNLOCK_THR (4),
    .SETTLE     (3)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .fsc  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pulse"},  {31'd0, bus.shift_fr_later}, 0);
    check({tag, "_locked"}, {31'd0, bus.locked}, 0);
    check({tag, "_d_enb"},  {31'd0, bus.d_enb}, 0);
    check({tag, "_pos"},    {27'd0, bus.shift_pos}, 0);
    check({tag, "_rcnt"},   {24'd0, bus.resync_count}, 0);
    check({tag, "_fail"},   {31'd0, bus.search_fail}, 0);
  endtask

  initial begin
    int npulse;
    int last;
    int ext_off;
    logic pulse_in;

    n_cmp = 0;
    n_bad = 0;
    rstn = 1'b0;
    bus.enable  = 1'b0;
    bus.resync  = 1'b0;
    bus.PATTERN = HDR;

    // Reset state
    tick();
    tick();
    check_all_zero("reset");
    rstn = 1'b1;
    tick();

    // Clean lock: IDLE->SEARCH then 16 matches, lock on the 17th edge
    bus.enable = 1'b1;
    npulse = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.shift_fr_later) npulse++;
    end
    check("clean_not_yet", {31'd0, bus.locked}, 0);
    tick();
    check("clean_locked", {31'd0, bus.locked}, 1);
    check("clean_d_enb", {31'd0, bus.d_enb}, 1);
    check("clean_pulses", npulse, 0);
    check("clean_pos", {27'd0, bus.shift_pos}, 0);

    // Lock loss: 3 misses, 1 match, 4 misses
    bus.PATTERN = BAD;
    tick(); tick(); tick();
    check("loss_hold_burst1", {31'd0, bus.locked}, 1);
    bus.PATTERN = HDR;
    tick();
    bus.PATTERN = BAD;
    tick(); tick(); tick();
    check("loss_hold_burst2", {31'd0, bus.locked}, 1);
    tick();
    check("loss_dropped", {31'd0, bus.locked}, 0);
    check("loss_d_enb", {31'd0, bus.d_enb}, 0);
    check("loss_rcnt", {24'd0, bus.resync_count}, 1);

    // Resync out of SEARCH then relock with clean headers
    bus.PATTERN = HDR;
    bus.resync  = 1'b1;
    tick();
    bus.resync  = 1'b0;
    check("resync_no_pulse", {31'd0, bus.shift_fr_later}, 0);
    for (int i = 0; i < 16; i++) tick();
    check("relock", {31'd0, bus.locked}, 1);
    check("relock_pos", {27'd0, bus.shift_pos}, 0);

    // Priority: disable wins over resync while locked
    bus.enable = 1'b0;
    bus.resync = 1'b1;
    tick();
    bus.resync = 1'b0;
    check("prio_locked", {31'd0, bus.locked}, 0);
    check("prio_d_enb", {31'd0, bus.d_enb}, 0);
    check("prio_rcnt", {24'd0, bus.resync_count}, 1);
    tick();
    check("idle_no_pulse", {31'd0, bus.shift_fr_later}, 0);

    // Slip search against an extractor whose true offset is 5
    ext_off = 0;
    npulse = 0;
    last = 0;
    bus.PATTERN = BAD;
    bus.enable = 1'b1;
    for (int c = 1; c <= 80 && !bus.locked; c++) begin
      pulse_in = bus.shift_fr_later;
      tick();
      if (pulse_in) ext_off++;
      bus.PATTERN = (ext_off == 5) ? HDR : BAD;
      if (pulse_in && bus.shift_fr_later) check("slip_single_cycle", 1, 0);
      if (bus.shift_fr_later) begin
        npulse++;
        if (npulse > 1) check("slip_gap", c - last, 5);
        last = c;
      end
    end
    check("slip_pulses", npulse, 5);
    check("slip_locked", {31'd0, bus.locked}, 1);
    check("slip_pos", {27'd0, bus.shift_pos}, 5);

    // Resync while locked keeps the loss counter
    bus.resync = 1'b1;
    tick();
    bus.resync = 1'b0;
    check("rs_locked", {31'd0, bus.locked}, 0);
    check("rs_rcnt", {24'd0, bus.resync_count}, 1);
    check("rs_fail", {31'd0, bus.search_fail}, 0);

    // Wrap/fail: headers never match; shift_pos starts from 5
    bus.enable = 1'b0;
    tick();
    bus.enable = 1'b1;
    bus.PATTERN = BAD;
    npulse = 0;
    for (int c = 1; c <= 300 && npulse < 33; c++) begin
      pulse_in = bus.shift_fr_later;
      tick();
      if (pulse_in && bus.shift_fr_later) check("wrap_single_cycle", 1, 0);
      if (bus.shift_fr_later) begin
        npulse++;
        check("wrap_pos", {27'd0, bus.shift_pos}, (5 + npulse) % 32);
        check("wrap_fail", {31'd0, bus.search_fail}, (npulse >= 32) ? 1 : 0);
      end
    end
    check("wrap_pulses", npulse, 33);

    // Async reset while the 33rd pulse is high, between clock edges
    #1 rstn = 1'b0;
    #1;
    check_all_zero("areset");
    @(posedge clk);
    #1 rstn = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
